nrzi_rx_decoder: RTL

NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

---
 rtl/nrzi_rx_decoder_if.sv | 23 ++
 rtl/nrzi_rx_decoder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/nrzi_rx_decoder_if.sv
// Bundle of NRZI line inputs, framing strobes and decoded-byte outputs.
// The decoder uses the slave view; the line source and sink use the master view.
interface nrzi_rx_decoder_if;
   logic       line_in;
   logic       line_en;
   logic       frame_start;
   logic       frame_end;
   logic [7:0] data_out;
   logic       data_valid;
   logic       stuff_err;
   logic       frame_abort;
   logic       busy;

   modport master (
      output line_in, line_en, frame_start, frame_end,
      input  data_out, data_valid, stuff_err, frame_abort, busy
   );

   modport slave (
      input  line_in, line_en, frame_start, frame_end,
      output data_out, data_valid, stuff_err, frame_abort, busy
   );
endinterface

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder with bit-unstuffing, LSB-first byte assembly and
// framing error reporting.
module nrzi_rx_decoder #(
   parameter logic IDLE_LEVEL = 1'b1,
   parameter int   STUFF_LEN  = 6
) (
   input logic              clk,
   input logic              rst_n,
   nrzi_rx_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;

   localparam logic [3:0] STUFF_LEN_C = 4'(STUFF_LEN);

   state_t     state_q, state_d;
   logic       prev_level_q, prev_level_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] ones_cnt_q, ones_cnt_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       stuff_err_q, stuff_err_d;
   logic       frame_abort_q, frame_abort_d;

   logic       dec_bit;
   logic [7:0] shifted;
   logic [3:0] ones_inc;

   assign dec_bit  = (bus.line_in == prev_level_q);
   assign shifted  = {dec_bit, shreg_q[7:1]};
   assign ones_inc = ones_cnt_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         prev_level_q  <= IDLE_LEVEL;
         shreg_q       <= 8'h00;
         bit_cnt_q     <= 3'd0;
         ones_cnt_q    <= 4'd0;
         data_out_q    <= 8'h00;
         data_valid_q  <= 1'b0;
         stuff_err_q   <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_level_q  <= prev_level_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         ones_cnt_q    <= ones_cnt_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         stuff_err_q   <= stuff_err_d;
         frame_abort_q <= frame_abort_d;
      end
   end

   // frame_start dominates frame_end, which in turn swallows any same-cycle sample.
   always_comb begin
      state_d       = state_q;
      prev_level_d  = prev_level_q;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      ones_cnt_d    = ones_cnt_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      stuff_err_d   = 1'b0;
      frame_abort_d = 1'b0;

      if (bus.frame_start) begin
         state_d      = DATA;
         prev_level_d = IDLE_LEVEL;
         shreg_d      = 8'h00;
         bit_cnt_d    = 3'd0;
         ones_cnt_d   = 4'd0;
      end else if (bus.frame_end && (state_q != IDLE)) begin
         state_d       = IDLE;
         frame_abort_d = (bit_cnt_q != 3'd0);
         bit_cnt_d     = 3'd0;
         ones_cnt_d    = 4'd0;
      end else if (bus.line_en) begin
         prev_level_d = bus.line_in;
         case (state_q)
            DATA: begin
               shreg_d   = shifted;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  data_out_d   = shifted;
                  data_valid_d = 1'b1;
               end
               if (dec_bit) begin
                  ones_cnt_d = ones_inc;
                  if (ones_inc == STUFF_LEN_C) begin
                     state_d = STUFF;
                  end
               end else begin
                  ones_cnt_d = 4'd0;
               end
            end
            STUFF: begin
               ones_cnt_d = 4'd0;
               if (dec_bit) begin
                  state_d     = IDLE;
                  stuff_err_d = 1'b1;
                  bit_cnt_d   = 3'd0;
               end else begin
                  state_d = DATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.stuff_err   = stuff_err_q;
   assign bus.frame_abort = frame_abort_q;
   assign bus.busy        = (state_q != IDLE);

endmodule
